// File: rtl/pulse_event_log.sv
// Timestamped event FIFO with a first-word-fall-through read port; drops on full.
// Optional PULSE_EVENT_LOG_DELTA_EN: ts field holds cycles since previous accepted event.
module pulse_event_log #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned TS_WIDTH = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          trigger,
    input  logic [7:0]                    index,
    input  logic                          clear,
    input  logic                          rd_pop,
    output logic                          rd_valid,
    output logic [8+TS_WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          overflow,
    output logic [15:0]                   drop_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned W  = 8 + TS_WIDTH;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]        mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]         count_q, count_d;
    logic [W-1:0]        rd_data_q, rd_data_d;
    logic                overflow_q, overflow_d;
    logic [15:0]         drop_q, drop_d;
    logic [TS_WIDTH-1:0] ts_field;
    logic [W-1:0]        wr_entry;
    logic                full, empty, do_pop, do_push, do_drop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_pop  = rd_pop && !empty && !clear;
    assign do_push = trigger && !clear && (!full || do_pop);
    assign do_drop = trigger && !clear && full && !do_pop;
    assign wr_entry = {index, ts_field};

`ifdef PULSE_EVENT_LOG_DELTA_EN
    logic [TS_WIDTH-1:0] delta_q, delta_d;

    // A push restarts counting so the next cycle already reads one elapsed cycle.
    always_comb begin
        delta_d = delta_q;
        if (clear) begin
            delta_d = '0;
        end else if (do_push) begin
            delta_d = TS_WIDTH'(1);
        end else if (!(&delta_q)) begin
            delta_d = delta_q + TS_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            delta_q <= '0;
        end else begin
            delta_q <= delta_d;
        end
    end

    assign ts_field = delta_q;
`else
    logic [TS_WIDTH-1:0] ts_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_WIDTH'(1);
        end
    end

    assign ts_field = ts_q;
`endif

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
            if (do_drop) begin
                overflow_d = 1'b1;
                if (drop_q != 16'hFFFF) begin
                    drop_d = drop_q + 16'd1;
                end
            end
        end
    end

    // The new head is the entry being written only when it lands as the sole entry.
    always_comb begin
        rd_data_d = rd_data_q;
        if (!clear && count_d != '0) begin
            if (do_push && wr_ptr_q == rd_ptr_d) begin
                rd_data_d = wr_entry;
            end else begin
                rd_data_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    assign rd_valid   = !empty;
    assign rd_data    = rd_data_q;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule
